// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Combinational helpers only; no latency.
// No flow control: these are plain constants and a helper function.
package seg7_scan_driver_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    localparam logic [2:0] IDX_HOUR_H   = 3'd0;
    localparam logic [2:0] IDX_HOUR_L   = 3'd1;
    localparam logic [2:0] IDX_MINUTE_H = 3'd2;
    localparam logic [2:0] IDX_MINUTE_L = 3'd3;
    localparam logic [2:0] IDX_SECOND_H = 3'd4;
    localparam logic [2:0] IDX_SECOND_L = 3'd5;

    // Field values are bit positions inside blink_mask
    localparam logic [1:0] FIELD_HOUR   = 2'd2;
    localparam logic [1:0] FIELD_MINUTE = 2'd1;
    localparam logic [1:0] FIELD_SECOND = 2'd0;

    function automatic logic [1:0] field_of(input logic [2:0] idx);
        case (idx)
            IDX_HOUR_H, IDX_HOUR_L:     field_of = FIELD_HOUR;
            IDX_MINUTE_H, IDX_MINUTE_L: field_of = FIELD_MINUTE;
            default:                    field_of = FIELD_SECOND;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// BCD nibble to active-high 7-segment pattern; codes 10..15 render a dash.
// Purely combinational, zero latency.
// No flow control.
module bcd_to_seg7_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes six BCD digits onto a shared 7-segment bus with blanking and field blink.
// All pins registered: pins reflect scan state one cycle later.
// No backpressure: inputs are sampled once per frame into shadow registers.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits,
    input  logic [2:0]  blink_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  dig_sel,
    output logic        frame_done
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0] DIG_OFF = {6{DIG_ACTIVE_LOW}};

    logic [SLOT_W-1:0]  slot_cnt;
    logic [2:0]         dig_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [23:0]        shadow_digits;
    logic [2:0]         shadow_mask;
    logic               load_pend;

    logic [23:0] cur_digits;
    logic [2:0]  cur_mask;
    logic [3:0]  cur_bcd;
    logic [6:0]  dec_pattern;
    logic        slot_last;
    logic        frame_end;
    logic        in_blank;
    logic        blinked;
    logic        visible;
    logic        is_colon;
    logic [5:0]  dig_onehot;

    // The first cycle after reset shows the live inputs so the frame opens on fresh data
    assign cur_digits = load_pend ? digits     : shadow_digits;
    assign cur_mask   = load_pend ? blink_mask : shadow_mask;

    always_comb begin
        cur_bcd = cur_digits[3:0];
        case (dig_idx)
            IDX_HOUR_H:   cur_bcd = cur_digits[23:20];
            IDX_HOUR_L:   cur_bcd = cur_digits[19:16];
            IDX_MINUTE_H: cur_bcd = cur_digits[15:12];
            IDX_MINUTE_L: cur_bcd = cur_digits[11:8];
            IDX_SECOND_H: cur_bcd = cur_digits[7:4];
            default:      cur_bcd = cur_digits[3:0];
        endcase
    end

    bcd_to_seg7_decode u_decode (
        .bcd     (cur_bcd),
        .pattern (dec_pattern)
    );

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign frame_end  = slot_last && (dig_idx == IDX_SECOND_L);
    assign in_blank   = (slot_cnt < BLANK_END);
    assign blinked    = !blink_phase && cur_mask[field_of(dig_idx)];
    assign visible    = !in_blank && !blinked;
    assign is_colon   = (dig_idx == IDX_HOUR_L) || (dig_idx == IDX_MINUTE_L);
    assign dig_onehot = 6'b100000 >> dig_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt      <= '0;
            dig_idx       <= IDX_HOUR_H;
            blink_cnt     <= '0;
            blink_phase   <= 1'b1;
            shadow_digits <= '0;
            shadow_mask   <= '0;
            load_pend     <= 1'b1;
            seg           <= SEG_OFF;
            dp            <= SEG_ACTIVE_LOW;
            dig_sel       <= DIG_OFF;
            frame_done    <= 1'b0;
        end else begin
            slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
            if (slot_last) begin
                dig_idx <= (dig_idx == IDX_SECOND_L) ? IDX_HOUR_H : dig_idx + 3'd1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            load_pend <= 1'b0;
            if (load_pend || frame_end) begin
                shadow_digits <= digits;
                shadow_mask   <= blink_mask;
            end

            seg        <= (visible ? dec_pattern : 7'b0) ^ SEG_OFF;
            dp         <= (visible && is_colon) ^ SEG_ACTIVE_LOW;
            dig_sel    <= (visible ? dig_onehot : 6'b0) ^ DIG_OFF;
            frame_done <= frame_end;
        end
    end

endmodule
